rs_alu: RTL and testbench
=========================

RS_ALU -- requirements
Module: rs_alu

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, number of entries; TAG_W, 4, ROB tag width; DATA_W, 32, operand width.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 dp_valid  input  1  dispatch request from the rename/dispatch stage.
REQ-005 dp_op  input  4  ALU opcode.
REQ-006 dp_dst_tag  input  TAG_W  destination ROB tag.
REQ-007 dp_src1_rdy / dp_src2_rdy  input  1  operand already available.
REQ-008 dp_src1_tag / dp_src2_tag  input  TAG_W  producer tag when not ready.
REQ-009 dp_src1_val / dp_src2_val  input  DATA_W  operand value when ready.
REQ-010 cdb_valid, cdb_tag, cdb_data  input  1/TAG_W/DATA_W  common data bus broadcast.
REQ-011 issue_valid  output  1  a ready entry is presented to the ALU.
REQ-012 issue_ready  input  1  ALU accepts the issue this cycle.
REQ-013 issue_op, issue_a, issue_b, issue_dst_tag  output  4/DATA_W/DATA_W/TAG_W  selected entry payload.
REQ-014 RSALU_full  output  1  all DEPTH entries valid; consumed by the hazard unit.
REQ-015 RSALU_rollback  input  1  mispredict flush from the hazard unit.

Function
REQ-016 Each entry SHALL hold: valid, op, dst_tag, per-source rdy/tag/val.
REQ-017 RSALU_full SHALL be derived combinationally from registered valid bits only (no dependence on dp_valid or issue handshake).
REQ-018 When dp_valid=1, RSALU_full=0 and RSALU_rollback=0, the payload SHALL be written into the lowest-index free entry on the next edge.
REQ-019 dp_valid while RSALU_full=1 SHALL be ignored, even if an issue completes in that cycle.
REQ-020 Wakeup: on cdb_valid, every valid entry whose non-ready source tag equals cdb_tag SHALL set rdy=1 and capture cdb_data at the next edge.
REQ-021 Dispatch bypass: if a dispatched non-ready source tag equals cdb_tag with cdb_valid=1 in the same cycle, the entry SHALL be written with that source ready and value cdb_data.
REQ-022 An entry is eligible when valid and both sources ready; issue_valid SHALL be combinational from registered state, so eligibility begins the cycle after the dispatch or wakeup edge.
REQ-023 issue_* SHALL present the selected eligible entry; with no eligible entry, issue_valid=0 and the payload outputs are 0.
REQ-024 issue_valid & issue_ready SHALL clear the selected entry's valid at the next edge; without issue_ready the same entry SHALL be held stable.
REQ-025 A freed slot SHALL be reusable by a dispatch in the following cycle; at most one dispatch and one issue per cycle.
REQ-026 RSALU_rollback=1 SHALL clear all valid bits at the next edge; it overrides dispatch, wakeup and issue in that cycle; issue_valid is unaffected in the rollback cycle itself.

Reset
REQ-027 rst=1 SHALL clear all valid, rdy and age state, giving RSALU_full=0 and issue_valid=0 in the following cycle, including when asserted mid-operation; rst overrides all other inputs.
REQ-028 Stored payload fields need not be reset; outputs SHALL still be 0 when issue_valid=0.

Configuration
REQ-029 Macro RS_AGE_ORDER_EN selects the issue policy.
REQ-030 Defined: each entry SHALL hold a saturating age counter, 0 on dispatch and +1 per cycle valid; selection is the greatest age, ties to lowest index.
REQ-031 Undefined: selection SHALL be the lowest-index eligible entry; no age state SHALL be synthesized.

Verification
REQ-032 Dispatch op=ADD, both ready (5,7), dst=3, issue_ready=1 -> next cycle issue_valid=1, a=5, b=7, dst=3; the cycle after that, issue_valid=0.
REQ-033 Four dispatches of entries waiting on tag 9 -> RSALU_full=1; fifth dispatch dropped; cdb 9/0x55 -> all four become eligible and issue over 4 cycles with a=0x55.
REQ-034 Dispatch src1 tag 2 not ready with cdb_valid, tag 2, data 0xAB in the same cycle -> entry issues next cycle with a=0xAB.
REQ-035 Three valid entries, RSALU_rollback=1 together with dp_valid=1 -> next cycle all entries empty, RSALU_full=0, issue_valid=0.
REQ-036 rst pulse while full and issue_ready=0 -> next cycle RSALU_full=0, issue_valid=0; then a dispatch lands in entry 0.
REQ-037 With RS_AGE_ORDER_EN: entry 2 dispatched before entry 0, both ready -> entry 2 issues first; without the macro -> entry 0 issues first.

Source files
------------

// File: rtl/rs_alu.sv
// ALU reservation station: DEPTH entries with CDB wakeup, dispatch bypass and single issue.
// Define RS_AGE_ORDER_EN for oldest-first issue; otherwise lowest-index-first.
module rs_alu #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dp_valid,
   input  logic [3:0]        dp_op,
   input  logic [TAG_W-1:0]  dp_dst_tag,
   input  logic              dp_src1_rdy,
   input  logic [TAG_W-1:0]  dp_src1_tag,
   input  logic [DATA_W-1:0] dp_src1_val,
   input  logic              dp_src2_rdy,
   input  logic [TAG_W-1:0]  dp_src2_tag,
   input  logic [DATA_W-1:0] dp_src2_val,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [3:0]        issue_op,
   output logic [DATA_W-1:0] issue_a,
   output logic [DATA_W-1:0] issue_b,
   output logic [TAG_W-1:0]  issue_dst_tag,
   output logic              RSALU_full,
   input  logic              RSALU_rollback
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0]  valid_reg, s1_rdy_reg, s2_rdy_reg, eligible;
   logic [3:0]        op_reg     [DEPTH];
   logic [TAG_W-1:0]  dst_reg    [DEPTH];
   logic [TAG_W-1:0]  s1_tag_reg [DEPTH];
   logic [TAG_W-1:0]  s2_tag_reg [DEPTH];
   logic [DATA_W-1:0] s1_val_reg [DEPTH];
   logic [DATA_W-1:0] s2_val_reg [DEPTH];
   logic [IDX_W-1:0]  free_idx, sel_idx;
   logic              dp_fire, issue_fire, bypass1, bypass2;

`ifdef RS_AGE_ORDER_EN
   localparam int AGE_W = 4;
   logic [AGE_W-1:0] age_reg [DEPTH];
   logic [AGE_W-1:0] best_age;
   logic             found;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_elig
         assign eligible[gi] = valid_reg[gi] & s1_rdy_reg[gi] & s2_rdy_reg[gi];
      end
   endgenerate

   assign RSALU_full = &valid_reg;
   assign dp_fire    = dp_valid & ~RSALU_full & ~RSALU_rollback;
   assign issue_fire = issue_valid & issue_ready;
   // Same-cycle CDB broadcast would otherwise be missed by an entry not yet written.
   assign bypass1    = ~dp_src1_rdy & cdb_valid & (cdb_tag == dp_src1_tag);
   assign bypass2    = ~dp_src2_rdy & cdb_valid & (cdb_tag == dp_src2_tag);

   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_reg[i]) free_idx = IDX_W'(i);
      end
   end

`ifdef RS_AGE_ORDER_EN
   // Strict greater-than keeps the lowest index on equal ages.
   always_comb begin
      sel_idx  = '0;
      best_age = '0;
      found    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (eligible[i] && (!found || age_reg[i] > best_age)) begin
            sel_idx  = IDX_W'(i);
            best_age = age_reg[i];
            found    = 1'b1;
         end
      end
   end
`else
   always_comb begin
      sel_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (eligible[i]) sel_idx = IDX_W'(i);
      end
   end
`endif

   always_comb begin
      issue_valid   = |eligible;
      issue_op      = '0;
      issue_a       = '0;
      issue_b       = '0;
      issue_dst_tag = '0;
      if (issue_valid) begin
         issue_op      = op_reg[sel_idx];
         issue_a       = s1_val_reg[sel_idx];
         issue_b       = s2_val_reg[sel_idx];
         issue_dst_tag = dst_reg[sel_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg  <= '0;
         s1_rdy_reg <= '0;
         s2_rdy_reg <= '0;
`ifdef RS_AGE_ORDER_EN
         for (int i = 0; i < DEPTH; i++) age_reg[i] <= '0;
`endif
      end else if (RSALU_rollback) begin
         valid_reg <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (dp_fire && free_idx == IDX_W'(i)) begin
               valid_reg[i]  <= 1'b1;
               op_reg[i]     <= dp_op;
               dst_reg[i]    <= dp_dst_tag;
               s1_rdy_reg[i] <= dp_src1_rdy | bypass1;
               s1_tag_reg[i] <= dp_src1_tag;
               s1_val_reg[i] <= bypass1 ? cdb_data : dp_src1_val;
               s2_rdy_reg[i] <= dp_src2_rdy | bypass2;
               s2_tag_reg[i] <= dp_src2_tag;
               s2_val_reg[i] <= bypass2 ? cdb_data : dp_src2_val;
`ifdef RS_AGE_ORDER_EN
               age_reg[i]    <= '0;
`endif
            end else begin
               if (issue_fire && sel_idx == IDX_W'(i)) valid_reg[i] <= 1'b0;
               if (valid_reg[i] && !s1_rdy_reg[i] && cdb_valid && cdb_tag == s1_tag_reg[i]) begin
                  s1_rdy_reg[i] <= 1'b1;
                  s1_val_reg[i] <= cdb_data;
               end
               if (valid_reg[i] && !s2_rdy_reg[i] && cdb_valid && cdb_tag == s2_tag_reg[i]) begin
                  s2_rdy_reg[i] <= 1'b1;
                  s2_val_reg[i] <= cdb_data;
               end
`ifdef RS_AGE_ORDER_EN
               if (valid_reg[i] && age_reg[i] != '1) age_reg[i] <= age_reg[i] + AGE_W'(1);
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_rs_alu.sv
// Directed self-checking bench for rs_alu: dispatch, wakeup, bypass, full, rollback, reset, issue order.
// Expected issue order follows RS_AGE_ORDER_EN when the bench is built with it.
module tb_rs_alu;
   logic        clk = 1'b0;
   logic        rst, dp_valid, dp_src1_rdy, dp_src2_rdy, cdb_valid;
   logic [3:0]  dp_op, dp_dst_tag, dp_src1_tag, dp_src2_tag, cdb_tag;
   logic [31:0] dp_src1_val, dp_src2_val, cdb_data;
   logic        issue_valid, issue_ready, RSALU_full, RSALU_rollback;
   logic [3:0]  issue_op, issue_dst_tag;
   logic [31:0] issue_a, issue_b;
   int          tests = 0;
   int          fails = 0;

   rs_alu #(.DEPTH(4), .TAG_W(4), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .dp_valid(dp_valid), .dp_op(dp_op), .dp_dst_tag(dp_dst_tag),
      .dp_src1_rdy(dp_src1_rdy), .dp_src1_tag(dp_src1_tag), .dp_src1_val(dp_src1_val),
      .dp_src2_rdy(dp_src2_rdy), .dp_src2_tag(dp_src2_tag), .dp_src2_val(dp_src2_val),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
      .issue_a(issue_a), .issue_b(issue_b), .issue_dst_tag(issue_dst_tag),
      .RSALU_full(RSALU_full), .RSALU_rollback(RSALU_rollback)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents one dispatch for a single cycle; CDB/rollback set by the caller apply to the same cycle.
   task automatic disp(input logic [3:0] op, input logic [3:0] dst,
                       input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                       input logic r2, input logic [3:0] t2, input logic [31:0] v2);
      dp_valid = 1'b1; dp_op = op; dp_dst_tag = dst;
      dp_src1_rdy = r1; dp_src1_tag = t1; dp_src1_val = v1;
      dp_src2_rdy = r2; dp_src2_tag = t2; dp_src2_val = v2;
      $display("[TB] dispatch op=%0d dst=%0d s1=%0b/%0d/%0h s2=%0b/%0d/%0h cdb=%0b/%0d rb=%0b",
               op, dst, r1, t1, v1, r2, t2, v2, cdb_valid, cdb_tag, RSALU_rollback);
      tick();
      dp_valid = 1'b0; cdb_valid = 1'b0; RSALU_rollback = 1'b0;
   endtask

   task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
      cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
      $display("[TB] cdb tag=%0d data=%0h", tag, data);
      tick();
      cdb_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; dp_valid = 1'b0; dp_op = '0; dp_dst_tag = '0;
      dp_src1_rdy = 1'b0; dp_src1_tag = '0; dp_src1_val = '0;
      dp_src2_rdy = 1'b0; dp_src2_tag = '0; dp_src2_val = '0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
      issue_ready = 1'b0; RSALU_rollback = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("reset_full", RSALU_full, 0);
      chk("reset_issue_valid", issue_valid, 0);
      chk("reset_issue_a", issue_a, 0);

      // Basic ADD, both operands ready
      issue_ready = 1'b1;
      disp(4'd0, 4'd3, 1, 0, 32'd5, 1, 0, 32'd7);
      chk("add_valid", issue_valid, 1);
      chk("add_a", issue_a, 5);
      chk("add_b", issue_b, 7);
      chk("add_dst", issue_dst_tag, 3);
      chk("add_op", issue_op, 0);
      tick();
      chk("add_done_valid", issue_valid, 0);
      chk("add_done_a", issue_a, 0);

      // Fill with four entries waiting on tag 9
      issue_ready = 1'b0;
      for (int k = 0; k < 4; k++) disp(4'd1, 4'(k), 0, 4'd9, 32'd0, 1, 0, 32'(k + 1));
      chk("fill_full", RSALU_full, 1);
      chk("fill_no_issue", issue_valid, 0);
      disp(4'd1, 4'd7, 1, 0, 32'h77, 1, 0, 32'h78);
      chk("fifth_dropped_full", RSALU_full, 1);
      chk("fifth_dropped_no_issue", issue_valid, 0);
      cdb(4'd9, 32'h55);
      chk("wake_valid", issue_valid, 1);
      chk("wake_a0", issue_a, 32'h55);
      chk("wake_dst0", issue_dst_tag, 0);
      issue_ready = 1'b1;
      // Dispatch while full and an issue completes in the same cycle must be ignored
      disp(4'd1, 4'd7, 1, 0, 32'h77, 1, 0, 32'h78);
      chk("after_issue0_full", RSALU_full, 0);
      for (int k = 1; k < 4; k++) begin
         chk("wake_issue_valid", issue_valid, 1);
         chk("wake_issue_a", issue_a, 32'h55);
         chk("wake_issue_b", issue_b, 32'(k + 1));
         chk("wake_issue_dst", issue_dst_tag, 32'(k));
         tick();
      end
      chk("wake_drained", issue_valid, 0);

      // Dispatch bypass from the CDB
      cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'hAB;
      disp(4'd2, 4'd5, 0, 4'd2, 32'h0, 1, 0, 32'h1);
      chk("bypass_valid", issue_valid, 1);
      chk("bypass_a", issue_a, 32'hAB);
      chk("bypass_dst", issue_dst_tag, 5);
      tick();
      chk("bypass_done", issue_valid, 0);

      // Non-matching CDB tag does not wake; matching one does
      cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 32'hEE;
      disp(4'd3, 4'd6, 0, 4'd6, 32'h0, 1, 0, 32'h2);
      chk("mismatch_no_wake", issue_valid, 0);
      cdb(4'd6, 32'h66);
      chk("late_wake_valid", issue_valid, 1);
      chk("late_wake_a", issue_a, 32'h66);
      tick();
      chk("late_wake_done", issue_valid, 0);

      // Rollback overrides a simultaneous dispatch
      issue_ready = 1'b0;
      for (int k = 1; k <= 3; k++) disp(4'd0, 4'(k), 1, 0, 32'(k), 1, 0, 32'(k));
      chk("rb_pre_dst", issue_dst_tag, 1);
      RSALU_rollback = 1'b1;
      chk("rb_cycle_valid", issue_valid, 1);
      disp(4'd0, 4'd9, 1, 0, 32'h9, 1, 0, 32'h9);
      chk("rb_full", RSALU_full, 0);
      chk("rb_issue_valid", issue_valid, 0);

      // Reset while full and stalled
      for (int k = 0; k < 4; k++) disp(4'd0, 4'(k), 1, 0, 32'(k), 1, 0, 32'(k));
      chk("rst_pre_full", RSALU_full, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_full", RSALU_full, 0);
      chk("rst_issue_valid", issue_valid, 0);
      disp(4'd4, 4'hA, 1, 0, 32'h11, 1, 0, 32'h12);
      chk("rst_redisp_dst", issue_dst_tag, 32'hA);
      chk("rst_redisp_a", issue_a, 32'h11);
      issue_ready = 1'b1;
      tick();
      chk("rst_redisp_done", issue_valid, 0);

      // Issue policy: entry 2 older than a re-used entry 0
      issue_ready = 1'b0;
      disp(4'd1, 4'd1, 1, 0, 32'h10, 1, 0, 32'h01);
      disp(4'd1, 4'd6, 0, 4'd13, 32'h0, 1, 0, 32'h06);
      disp(4'd1, 4'd2, 1, 0, 32'h22, 1, 0, 32'h02);
      chk("order_first_dst", issue_dst_tag, 1);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      chk("order_e2_dst", issue_dst_tag, 2);
      disp(4'd1, 4'd4, 1, 0, 32'h44, 1, 0, 32'h04);
`ifdef RS_AGE_ORDER_EN
      chk("order_pick_dst", issue_dst_tag, 2);
      issue_ready = 1'b1;
      tick();
      chk("order_second_dst", issue_dst_tag, 4);
`else
      chk("order_pick_dst", issue_dst_tag, 4);
      issue_ready = 1'b1;
      tick();
      chk("order_second_dst", issue_dst_tag, 2);
`endif
      tick();
      chk("order_waiting_only", issue_valid, 0);
      cdb(4'd13, 32'hD);
      chk("order_last_dst", issue_dst_tag, 6);
      chk("order_last_a", issue_a, 32'hD);
      tick();
      chk("order_empty", issue_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
